custom_axi_engine: RTL

Parametrised register-driven processing engine. It is the next generation of the single-shot IDLE/BUSY/DONE/ERROR increment block. Software writes an operand, step, iteration count and mode through the register file. The engine then applies the selected arithmetic operation once per cycle for the programmed number of iterations, and reports status, overflow and error cause back to the register file. Completion and error states are held until software acknowledges them.

---
 rtl/custom_axi_engine.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/custom_axi_engine.sv
// Iterative arithmetic engine: applies add/sub/shl to a latched operand once per cycle for N iterations.
// Latency: start accepted in IDLE -> N BUSY cycles -> DONE (data_o, done_o) N+1 cycles after start.
// Backpressure: none; DONE/ERROR are held until ack_i, and start_i is only sampled while IDLE.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   start_i                  job request (IDLE only)
//   data_i, step_i, iter_i   initial operand, per-iteration operand, iteration count
//   mode_i                   00 add, 01 sub, 10 shift-left by 1, 11 reserved
//   abort_i                  cancel a running job (BUSY only)
//   ack_i                    release DONE/ERROR back to IDLE
//   data_o                   result register, loaded only on successful completion
//   status_o, busy_o         registered state and its BUSY decode
//   done_o                   one-cycle pulse on entry to DONE
//   ovf_o                    sticky overflow/underflow of the current job
//   err_code_o               00 none, 01 zero count, 10 bad mode, 11 aborted
//   iter_left_o              remaining iterations

package custom_axi_ip_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERROR = 2'd3
    } status_e;
endpackage

module custom_axi_engine #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 8,
    parameter int SATURATE   = 0
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            start_i,
    input  logic [DATA_WIDTH-1:0]           data_i,
    input  logic [DATA_WIDTH-1:0]           step_i,
    input  logic [CNT_WIDTH-1:0]            iter_i,
    input  logic [1:0]                      mode_i,
    input  logic                            abort_i,
    input  logic                            ack_i,
    output logic [DATA_WIDTH-1:0]           data_o,
    output custom_axi_ip_pkg::status_e      status_o,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            ovf_o,
    output logic [1:0]                      err_code_o,
    output logic [CNT_WIDTH-1:0]            iter_left_o
);
    import custom_axi_ip_pkg::*;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    localparam logic [1:0] MODE_ADD = 2'b00;
    localparam logic [1:0] MODE_SUB = 2'b01;
    localparam logic [1:0] MODE_SHL = 2'b10;
    localparam logic [1:0] MODE_RSV = 2'b11;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_ZERO  = 2'b01;
    localparam logic [1:0] ERR_MODE  = 2'b10;
    localparam logic [1:0] ERR_ABORT = 2'b11;

    status_e                state_q, state_d;
    logic [DATA_WIDTH-1:0]  acc_q;
    logic [DATA_WIDTH-1:0]  step_q;
    logic [DATA_WIDTH-1:0]  data_q;
    logic [1:0]             mode_q;
    logic [1:0]             err_q;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic                   ovf_q;
    logic                   done_q;

    // FSM decisions, shared with the datapath register block
    logic                   accept;
    logic                   err_zero;
    logic                   err_mode;
    logic                   abort_hit;
    logic                   step_en;
    logic                   last_iter;

    // One iteration of the selected operation
    logic [DATA_WIDTH:0]    add_w;
    logic [DATA_WIDTH:0]    sub_w;
    logic [DATA_WIDTH-1:0]  op_res;
    logic                   op_ovf;

    assign add_w = {1'b0, acc_q} + {1'b0, step_q};
    assign sub_w = {1'b0, acc_q} - {1'b0, step_q};

    always_comb begin
        op_res = acc_q;
        op_ovf = 1'b0;
        case (mode_q)
            MODE_ADD: begin
                op_res = add_w[DATA_WIDTH-1:0];
                op_ovf = add_w[DATA_WIDTH];
            end
            MODE_SUB: begin
                op_res = sub_w[DATA_WIDTH-1:0];
                op_ovf = sub_w[DATA_WIDTH];
            end
            MODE_SHL: begin
                op_res = {acc_q[DATA_WIDTH-2:0], 1'b0};
                op_ovf = acc_q[DATA_WIDTH-1];
            end
            default: begin
                // reserved mode is rejected at start, so it never reaches BUSY
                op_res = acc_q;
                op_ovf = 1'b0;
            end
        endcase
        // Clamp: subtract underflows toward zero, add/shift overflow toward all-ones
        if ((SATURATE != 0) && op_ovf) begin
            op_res = (mode_q == MODE_SUB) ? '0 : '1;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        err_zero  = 1'b0;
        err_mode  = 1'b0;
        abort_hit = 1'b0;
        step_en   = 1'b0;
        last_iter = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    // zero count is checked first so it wins over a bad mode
                    if (iter_i == '0) begin
                        err_zero = 1'b1;
                        state_d  = ST_ERROR;
                    end else if (mode_i == MODE_RSV) begin
                        err_mode = 1'b1;
                        state_d  = ST_ERROR;
                    end else begin
                        accept  = 1'b1;
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                // abort beats the final iteration: no result, no done pulse
                if (abort_i) begin
                    abort_hit = 1'b1;
                    state_d   = ST_ERROR;
                end else begin
                    step_en = 1'b1;
                    if (cnt_q == CNT_ONE) begin
                        last_iter = 1'b1;
                        state_d   = ST_DONE;
                    end
                end
            end
            ST_DONE, ST_ERROR: begin
                if (ack_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q  <= '0;
            step_q <= '0;
            data_q <= '0;
            mode_q <= MODE_ADD;
            err_q  <= ERR_NONE;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (err_zero) begin
                err_q <= ERR_ZERO;
            end
            if (err_mode) begin
                err_q <= ERR_MODE;
            end
            if (accept) begin
                acc_q  <= data_i;
                step_q <= step_i;
                mode_q <= mode_i;
                cnt_q  <= iter_i;
                ovf_q  <= 1'b0;
                err_q  <= ERR_NONE;
            end
            if (abort_hit) begin
                err_q <= ERR_ABORT;
            end
            if (step_en) begin
                acc_q <= op_res;
                cnt_q <= cnt_q - CNT_ONE;
                ovf_q <= ovf_q | op_ovf;
            end
            if (last_iter) begin
                data_q <= op_res;
                done_q <= 1'b1;
            end
        end
    end

    assign data_o      = data_q;
    assign status_o    = state_q;
    assign busy_o      = (state_q == ST_BUSY);
    assign done_o      = done_q;
    assign ovf_o       = ovf_q;
    assign err_code_o  = err_q;
    assign iter_left_o = cnt_q;

endmodule
